// File: rtl/fu_arb_pkg.sv
// Shared definitions for the function-unit arbiter: FunctionSelect opcodes,
// FSM state encoding and flag bit positions within {V,C,N,Z}.
package fu_arb_pkg;

  localparam logic [3:0] FS_PASSA  = 4'd0;
  localparam logic [3:0] FS_INC    = 4'd1;
  localparam logic [3:0] FS_ADD    = 4'd2;
  localparam logic [3:0] FS_ADDC   = 4'd3;
  localparam logic [3:0] FS_SUBB   = 4'd4;
  localparam logic [3:0] FS_SUB    = 4'd5;
  localparam logic [3:0] FS_DEC    = 4'd6;
  localparam logic [3:0] FS_PASSA2 = 4'd7;
  localparam logic [3:0] FS_AND    = 4'd8;
  localparam logic [3:0] FS_OR     = 4'd9;
  localparam logic [3:0] FS_XOR    = 4'd10;
  localparam logic [3:0] FS_NOTA   = 4'd11;
  localparam logic [3:0] FS_PASSB  = 4'd12;
  localparam logic [3:0] FS_SHR    = 4'd13;
  localparam logic [3:0] FS_SHL    = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/fu_arbiter_if.sv
// Bundle of requester, function-unit and response signals around fu_arbiter.
// slave = the arbiter; master = requesters plus the function unit.
interface fu_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int SHIFTER_WIDTH = 5,
  parameter int NUM_REQ       = 2,
  parameter int ID_WIDTH      = 2
);

  // Handshakes: a transfer happens on a rising clk edge where valid & ready
  // are both high for the same bit; a raised valid and its fields stay
  // stable until that transfer, ready may depend combinationally on valid.
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               req_lock;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_b;
  logic [NUM_REQ*4-1:0]             req_fs;
  logic [NUM_REQ*SHIFTER_WIDTH-1:0] req_sh;

  logic [DATA_WIDTH-1:0]            fu_a;
  logic [DATA_WIDTH-1:0]            fu_b;
  logic [3:0]                       fu_fs;
  logic [SHIFTER_WIDTH-1:0]         fu_sh;
  logic [DATA_WIDTH-1:0]            fu_result;
  logic [3:0]                       fu_flags;

  logic [NUM_REQ-1:0]               rsp_valid;
  logic [NUM_REQ-1:0]               rsp_ready;
  logic [DATA_WIDTH-1:0]            rsp_result;
  logic [3:0]                       rsp_flags;
  logic [ID_WIDTH-1:0]              rsp_id;

  modport slave (
    input  req_valid, req_lock, req_a, req_b, req_fs, req_sh,
    input  fu_result, fu_flags, rsp_ready,
    output req_ready, fu_a, fu_b, fu_fs, fu_sh,
    output rsp_valid, rsp_result, rsp_flags, rsp_id
  );

  modport master (
    output req_valid, req_lock, req_a, req_b, req_fs, req_sh,
    output fu_result, fu_flags, rsp_ready,
    input  req_ready, fu_a, fu_b, fu_fs, fu_sh,
    input  rsp_valid, rsp_result, rsp_flags, rsp_id
  );

endinterface

// File: rtl/fu_rr_arbiter.sv
// Combinational round-robin pick: first valid bit at or above ptr, otherwise
// the first valid bit from 0. Produces a one-hot grant and its index.
module fu_rr_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  valid,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] gid
);

  logic found;

  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i] && (ID_WIDTH'(i) >= ptr)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gid      = ID_WIDTH'(i);
      end
    end
    // Wrapped half of the scan, only reached when nothing at/above ptr is valid.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gid      = ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/fu_arbiter.sv
// Round-robin sharing of one combinational function unit: IDLE -> EXEC -> RESP.
// Define FU_ARB_LOCK_EN to let req_lock keep the grant for the next op.
module fu_arbiter
  import fu_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int SHIFTER_WIDTH = 5,
  parameter int NUM_REQ       = 2,
  parameter int ID_WIDTH      = 2
) (
  input  logic         clk,
  input  logic         rst,
  fu_arbiter_if.slave  bus,
  output state_e       dbg_state
);

  state_e                   state_q, state_d;
  logic [ID_WIDTH-1:0]      ptr_q, id_q, gid, rr_gid, ptr_nxt;
  logic [NUM_REQ-1:0]       rr_grant, grant, id_onehot;
  logic                     fire, locked_grant;
  logic [DATA_WIDTH-1:0]    a_q, b_q, a_sel, b_sel, res_q;
  logic [3:0]               fs_q, fs_sel, flags_q;
  logic [SHIFTER_WIDTH-1:0] sh_q, sh_sel;

  fu_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .gid   (rr_gid)
  );

  assign id_onehot = NUM_REQ'(1) << id_q;

`ifdef FU_ARB_LOCK_EN
  logic lock_q;

  // A lock only survives into the IDLE right after the locked op; it lapses
  // as soon as its owner is seen idle there.
  assign locked_grant = (state_q == IDLE) && lock_q && |(bus.req_valid & id_onehot);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (fire) begin
      lock_q <= |(bus.req_lock & grant);
    end else if (state_q == IDLE && !(|(bus.req_valid & id_onehot))) begin
      lock_q <= 1'b0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock  = ^bus.req_lock;
  assign locked_grant = 1'b0;
`endif

  assign grant   = locked_grant ? id_onehot : rr_grant;
  assign gid     = locked_grant ? id_q : rr_gid;
  assign ptr_nxt = (gid == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gid + 1'b1;

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    fs_sel = '0;
    sh_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel  = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_sel  = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
        fs_sel = bus.req_fs[i*4 +: 4];
        sh_sel = bus.req_sh[i*SHIFTER_WIDTH +: SHIFTER_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fire          = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = grant;
        fire          = |grant;
        if (fire) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        bus.rsp_valid = id_onehot;
        if (|(bus.rsp_ready & id_onehot)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Captured operands drive the function unit continuously, so they hold
  // their last values between ops and clear only on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      fs_q    <= FS_PASSA;
      sh_q    <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      if (fire) begin
        a_q  <= a_sel;
        b_q  <= b_sel;
        fs_q <= fs_sel;
        sh_q <= sh_sel;
        id_q <= gid;
        if (!locked_grant) ptr_q <= ptr_nxt;
      end
      if (state_q == EXEC) begin
        res_q   <= bus.fu_result;
        flags_q <= bus.fu_flags;
      end
    end
  end

  assign bus.fu_a       = a_q;
  assign bus.fu_b       = b_q;
  assign bus.fu_fs      = fs_q;
  assign bus.fu_sh      = sh_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.rsp_id     = id_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fu_arbiter.sv
// Directed bench for fu_arbiter with a behavioural function unit and an
// expected-response queue; covers latency, round-robin, backpressure, reset and lock.
module tb_fu_arbiter;
  import fu_arb_pkg::*;

  localparam int DW = 32;
  localparam int SW = 5;
  localparam int NR = 2;
  localparam int IW = 2;
  localparam int W  = IW + 4 + DW;

  logic   clk = 1'b0;
  logic   rst;
  state_e dbg_state;

  fu_arbiter_if #(.DATA_WIDTH(DW), .SHIFTER_WIDTH(SW), .NUM_REQ(NR), .ID_WIDTH(IW)) bus ();

  fu_arbiter #(.DATA_WIDTH(DW), .SHIFTER_WIDTH(SW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- function unit model ----------------
  logic [DW:0] fu_s;
  logic        fu_v;
  always_comb begin
    fu_s = '0;
    fu_v = 1'b0;
    case (bus.fu_fs)
      FS_PASSA, FS_PASSA2: fu_s = {1'b0, bus.fu_a};
      FS_INC:  fu_s = {1'b0, bus.fu_a} + 33'd1;
      FS_ADD: begin
        fu_s = {1'b0, bus.fu_a} + {1'b0, bus.fu_b};
        fu_v = (bus.fu_a[DW-1] == bus.fu_b[DW-1]) && (fu_s[DW-1] != bus.fu_a[DW-1]);
      end
      FS_ADDC: fu_s = {1'b0, bus.fu_a} + {1'b0, bus.fu_b} + 33'd1;
      FS_SUBB: fu_s = {1'b0, bus.fu_a} + {1'b0, ~bus.fu_b};
      FS_SUB: begin
        fu_s = {1'b0, bus.fu_a} + {1'b0, ~bus.fu_b} + 33'd1;
        fu_v = (bus.fu_a[DW-1] != bus.fu_b[DW-1]) && (fu_s[DW-1] != bus.fu_a[DW-1]);
      end
      FS_DEC:   fu_s = {1'b0, bus.fu_a} + {1'b0, {DW{1'b1}}};
      FS_AND:   fu_s = {1'b0, bus.fu_a & bus.fu_b};
      FS_OR:    fu_s = {1'b0, bus.fu_a | bus.fu_b};
      FS_XOR:   fu_s = {1'b0, bus.fu_a ^ bus.fu_b};
      FS_NOTA:  fu_s = {1'b0, ~bus.fu_a};
      FS_PASSB: fu_s = {1'b0, bus.fu_b};
      FS_SHR:   fu_s = {1'b0, bus.fu_a >> bus.fu_sh};
      FS_SHL:   fu_s = {1'b0, bus.fu_a << bus.fu_sh};
      default:  fu_s = '0;
    endcase
    bus.fu_result = fu_s[DW-1:0];
    bus.fu_flags  = {fu_v, fu_s[DW], fu_s[DW-1], (fu_s[DW-1:0] == '0)};
  end

  // ---------------- scoreboard ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pend[NR];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.rsp_ready = '0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic issue(input int id, input logic [3:0] fs, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [SW-1:0] sh,
                       input logic [DW-1:0] er, input logic [3:0] ef);
    bus.req_a[id*DW +: DW]  = a;
    bus.req_b[id*DW +: DW]  = b;
    bus.req_fs[id*4 +: 4]   = fs;
    bus.req_sh[id*SW +: SW] = sh;
    bus.req_valid[id]       = 1'b1;
    pend[id]                = {IW'(id), ef, er};
  endtask

  // Waits (bounded) for a grant, checks it is the expected one-hot, lets the
  // handshake edge pass and drops the winner's valid.
  task automatic accept(input int exp_gid, input string tag);
    bit got = 1'b0;
    int gid = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (|bus.req_ready) got = 1'b1;
      else @(negedge clk);
    end
    for (int i = 0; i < NR; i++) begin
      if (bus.req_ready[i] && gid < 0) gid = i;
    end
    check(tag, bus.req_ready, NR'(1) << exp_gid);
    if (gid < 0) return;
    exp_q.push_back(pend[gid]);
    @(negedge clk);
    bus.req_valid[gid] = 1'b0;
  endtask

  // Waits (bounded) for a response, optionally stalls it with only the other
  // rsp_ready bits high, then accepts it and compares with the queue head.
  task automatic take_rsp(input int stall);
    bit           got = 1'b0;
    logic [W-1:0] exp;
    logic [NR-1:0] oh;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (|bus.rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
    check("rsp_seen", got, 1);
    if (!got) return;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    oh  = NR'(1) << exp[W-1 -: IW];
    check("rsp_valid", bus.rsp_valid, oh);
    check("rsp_data", {bus.rsp_id, bus.rsp_flags, bus.rsp_result}, exp);
    for (int s = 0; s < stall; s++) begin
      bus.rsp_ready = ~oh;
      @(negedge clk);
      #1;
      check("bp_valid", bus.rsp_valid, oh);
      check("bp_data", {bus.rsp_id, bus.rsp_flags, bus.rsp_result}, exp);
      check("bp_no_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = oh;
    @(negedge clk);
    bus.rsp_ready = '0;
    #1;
    check("rsp_drop", bus.rsp_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_fs    = '0;
    bus.req_sh    = '0;
    bus.rsp_ready = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_fu_a", bus.fu_a, 0);
    check("rst_fu_b", bus.fu_b, 0);
    check("rst_fu_fs", bus.fu_fs, 0);
    check("rst_fu_sh", bus.fu_sh, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_flags", bus.rsp_flags, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Single op with exact latency.
    issue(0, FS_ADD, 32'd5, 32'd7, 5'd0, 32'd12, 4'b0000);
    accept(0, "t1_grant");
    #1;
    check("t1_state_exec", dbg_state, EXEC);
    check("t1_fu_a", bus.fu_a, 5);
    check("t1_fu_b", bus.fu_b, 7);
    check("t1_fu_fs", bus.fu_fs, FS_ADD);
    check("t1_no_rsp_yet", bus.rsp_valid, 0);
    @(negedge clk);
    #1;
    check("t1_latency", bus.rsp_valid, 2'b01);
    take_rsp(0);
    check("t1_fu_a_hold", bus.fu_a, 5);
    check("t1_fu_fs_hold", bus.fu_fs, FS_ADD);
    check("t1_state_idle", dbg_state, IDLE);

    // Overflow, zero, undefined opcode, shift amount.
    issue(0, FS_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 4'b1010);
    accept(0, "ovf_grant");
    take_rsp(0);
    issue(1, FS_SUB, 32'd9, 32'd9, 5'd0, 32'd0, 4'b0101);
    accept(1, "zero_grant");
    take_rsp(0);
    issue(0, 4'hF, 32'd3, 32'd4, 5'd2, 32'd0, 4'b0001);
    accept(0, "undef_grant");
    #1;
    check("undef_fs_pass", bus.fu_fs, 4'hF);
    take_rsp(0);
    issue(1, FS_SHL, 32'd1, 32'd0, 5'd4, 32'd16, 4'b0000);
    accept(1, "shl_grant");
    take_rsp(0);

    // Contention from reset: 0, 1, 0, 1 with the pointer wrapping.
    do_reset();
    issue(0, FS_ADD, 32'd1, 32'd2, 5'd0, 32'd3, 4'b0000);
    issue(1, FS_ADD, 32'd10, 32'd20, 5'd0, 32'd30, 4'b0000);
    accept(0, "cont_g0");
    take_rsp(0);
    issue(0, FS_PASSB, 32'd0, 32'd77, 5'd0, 32'd77, 4'b0000);
    accept(1, "cont_g1");
    take_rsp(0);
    issue(1, FS_DEC, 32'd5, 32'd0, 5'd0, 32'd4, 4'b0100);
    accept(0, "cont_g2");
    take_rsp(0);
    accept(1, "cont_g3");
    take_rsp(0);

    // Backpressure on requester 1 while requester 0 waits.
    issue(1, FS_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000, 4'b0000);
    accept(1, "bp_grant");
    issue(0, FS_INC, 32'd41, 32'd0, 5'd0, 32'd42, 4'b0000);
    take_rsp(5);
    accept(0, "bp_next_grant");
    take_rsp(0);

    // Reset while the response is pending.
    issue(0, FS_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 4'b0000);
    accept(0, "rr_grant");
    @(negedge clk);
    #1;
    check("rr_rsp_pending", bus.rsp_valid, 2'b01);
    rst = 1'b1;
    #1;
    check("rr_rsp_valid", bus.rsp_valid, 0);
    check("rr_rsp_result", bus.rsp_result, 0);
    check("rr_fu_a", bus.fu_a, 0);
    check("rr_fu_fs", bus.fu_fs, 0);
    check("rr_state", dbg_state, IDLE);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("rr_no_rsp", bus.rsp_valid, 0);
    end

    // Lock: requester 0 holds the grant only when the lock feature is built in.
    do_reset();
    bus.req_lock[0] = 1'b1;
    issue(0, FS_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 4'b0000);
    issue(1, FS_ADD, 32'd4, 32'd4, 5'd0, 32'd8, 4'b0000);
    accept(0, "lock_g0");
    take_rsp(0);
    issue(0, FS_ADD, 32'd6, 32'd6, 5'd0, 32'd12, 4'b0000);
`ifdef FU_ARB_LOCK_EN
    accept(0, "lock_g1_locked");
`else
    accept(1, "lock_g1_rr");
`endif
    take_rsp(0);
    bus.req_lock = '0;
`ifdef FU_ARB_LOCK_EN
    accept(1, "lock_g2");
`else
    accept(0, "lock_g2");
`endif
    take_rsp(0);

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
